// File: rtl/ab_seq_pkg.sv
// Shared types and default widths for the a-then-b stimulus generator.
package ab_seq_pkg;

  localparam int CNT_W_DEF = 8;
  localparam int GAP_W_DEF = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND_A,
    S_SEND_B,
    S_CHECK,
    S_GAP,
    S_FINISH
  } state_t;

endpackage

// File: rtl/ab_seq_gen.sv
// Drives repeated a-then-b patterns into a sequence detector and scores its y response.
module ab_seq_gen
  import ab_seq_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int GAP_W = GAP_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic [GAP_W-1:0] gap,
  input  logic             y_in,
  output logic             a,
  output logic             b,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] hit_cnt,
  output logic             err
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] rem;
  logic [GAP_W-1:0] gap_lat;
  logic [GAP_W-1:0] gap_cnt;
  logic             last;

  // rem counts down at each CHECK, so 1 means the pattern being checked is the last one
  assign last = (rem == CNT_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = (count == '0) ? S_FINISH : S_SEND_A;
      S_SEND_A: state_nxt = S_SEND_B;
      S_SEND_B: state_nxt = S_CHECK;
      S_CHECK: begin
        if (last)               state_nxt = S_FINISH;
        else if (gap_lat == '0) state_nxt = S_SEND_A;
        else                    state_nxt = S_GAP;
      end
      S_GAP:    if (gap_cnt == '0) state_nxt = S_SEND_A;
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem     <= '0;
      gap_lat <= '0;
      gap_cnt <= '0;
      hit_cnt <= '0;
      err     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            rem     <= count;
            gap_lat <= gap;
            hit_cnt <= '0;
            err     <= 1'b0;
          end
        end
        S_CHECK: begin
          rem <= rem - CNT_W'(1);
          if (y_in) hit_cnt <= hit_cnt + CNT_W'(1);
          else      err     <= 1'b1;
          // gap_cnt holds the cycles still to spend in GAP after the current one
          gap_cnt <= gap_lat - GAP_W'(1);
        end
        S_GAP: begin
          if (gap_cnt != '0) gap_cnt <= gap_cnt - GAP_W'(1);
          if (y_in) err <= 1'b1;
        end
        S_SEND_A, S_SEND_B, S_FINISH: begin
          if (y_in) err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign a    = (state == S_SEND_A);
  assign b    = (state == S_SEND_B);
  assign busy = (state != S_IDLE);
  assign done = (state == S_FINISH);

endmodule

// File: tb/tb_ab_seq_gen.sv
// Self-checking bench: ab_seq_gen looped through a behavioural a-then-b detector.
module tb_ab_seq_gen;

  localparam int CNT_W = 8;
  localparam int GAP_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [CNT_W-1:0] count;
  logic [GAP_W-1:0] gap;
  logic             y_in;
  logic             a, b, busy, done, err;
  logic [CNT_W-1:0] hit_cnt;

  // detector peer: y rises the cycle after it sees a followed by b
  logic prev_a, det_y;
  logic ovr_en, ovr_val;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_a <= 1'b0;
      det_y  <= 1'b0;
    end else begin
      prev_a <= a;
      det_y  <= prev_a & b;
    end
  end

  assign y_in = ovr_en ? ovr_val : det_y;

  ab_seq_gen #(.CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
    .clk(clk), .reset(reset), .start(start), .count(count), .gap(gap),
    .y_in(y_in), .a(a), .b(b), .busy(busy), .done(done),
    .hit_cnt(hit_cnt), .err(err)
  );

  // Cycle-by-cycle expectation of one run: per cycle a code 0=A 1=B 2=CHECK 3=GAP 4=FINISH.
  // pos/val optionally force y_in to val in cycle pos (1-based from the first cycle after start).
  task automatic do_run(input int n, input int g, input int pos, input bit val, input string tag);
    int        codes[$];
    int        hit;
    bit        er;
    bit        y;
    logic [3:0] exp_v, got_v;
    logic [CNT_W-1:0] exp_hit;
    codes = {};
    for (int p = 0; p < n; p++) begin
      codes.push_back(0); codes.push_back(1); codes.push_back(2);
      if (p < n - 1) for (int q = 0; q < g; q++) codes.push_back(3);
    end
    codes.push_back(4);
    hit = 0; er = 1'b0;
    @(negedge clk);
    start = 1'b1; count = CNT_W'(n); gap = GAP_W'(g);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < codes.size(); i++) begin
      ovr_en  = ((i + 1) == pos);
      ovr_val = val;
      exp_v = {codes[i] == 0, codes[i] == 1, 1'b1, codes[i] == 4};
      got_v = {a, b, busy, done};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL %s cycle %0d {a,b,busy,done}: got %b want %b", tag, i + 1, got_v, exp_v);
      end
      if (i == 0) begin
        checks++;
        if (hit_cnt !== '0 || err !== 1'b0) begin
          errors++;
          $display("FAIL %s clear-on-start: hit_cnt=%0d err=%b want 0/0", tag, hit_cnt, err);
        end
      end
      y = ovr_en ? val : (codes[i] == 2);
      if (codes[i] == 2) begin
        if (y) hit++; else er = 1'b1;
      end else if (y) er = 1'b1;
      @(negedge clk);
    end
    ovr_en = 1'b0;
    exp_hit = CNT_W'(hit);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hit_cnt !== exp_hit || err !== er) begin
      errors++;
      $display("FAIL %s end: busy=%b done=%b hit_cnt=%0d err=%b want 0 0 %0d %b",
               tag, busy, done, hit_cnt, err, exp_hit, er);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (hit_cnt !== exp_hit || err !== er) begin
      errors++;
      $display("FAIL %s hold: hit_cnt=%0d err=%b want %0d %b", tag, hit_cnt, err, exp_hit, er);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; count = '0; gap = '0; ovr_en = 1'b0; ovr_val = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({a, b, busy, done, err} !== 5'b0 || hit_cnt !== '0) begin
      errors++;
      $display("FAIL reset_state: a=%b b=%b busy=%b done=%b err=%b hit=%0d want all 0",
               a, b, busy, done, err, hit_cnt);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_basic();   do_run(3, 0, -1, 1'b0, "basic_c3_g0");  endtask
  task automatic test_gap();     do_run(2, 5, -1, 1'b0, "gap_c2_g5");    endtask
  task automatic test_zero();    do_run(0, 3, -1, 1'b0, "zero_count");   endtask
  // 2nd CHECK of count=4, gap=0 is cycle 6
  task automatic test_miss();    do_run(4, 0, 6, 1'b0, "miss_check2");   endtask
  task automatic test_after_err(); do_run(1, 2, -1, 1'b0, "clear_after_err"); endtask
  // cycles 1-3 pattern 1, cycle 4 first GAP cycle
  task automatic test_gap_hit(); do_run(2, 3, 4, 1'b1, "y_in_gap");      endtask
  task automatic test_idle_y();  do_run(2, 1, 2, 1'b1, "y_in_send_b");   endtask
  task automatic test_max();     do_run(255, 0, -1, 1'b0, "max_count");  endtask

  task automatic test_midrun_reset();
    @(negedge clk);
    start = 1'b1; count = CNT_W'(3); gap = '0;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (b !== 1'b1) begin
      errors++;
      $display("FAIL midrun_pos: b=%b want 1 in SEND_B of pattern 2", b);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({a, b, busy, done, err} !== 5'b0 || hit_cnt !== '0) begin
      errors++;
      $display("FAIL midrun_reset: a=%b b=%b busy=%b done=%b err=%b hit=%0d want all 0",
               a, b, busy, done, err, hit_cnt);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL no_restart cycle %0d: busy=%b done=%b want 0 0", i, busy, done);
      end
    end
    do_run(1, 0, -1, 1'b0, "after_reset_c1");
  endtask

  // start held through FINISH: ignored there, accepted in the next IDLE
  task automatic test_back_to_back();
    logic [3:0] exp_v[7];
    logic [3:0] got_v;
    exp_v = '{4'b1010, 4'b0110, 4'b0010, 4'b0011, 4'b0000, 4'b1010, 4'b0110};
    @(negedge clk);
    start = 1'b1; count = CNT_W'(1); gap = '0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      got_v = {a, b, busy, done};
      checks++;
      if (got_v !== exp_v[i]) begin
        errors++;
        $display("FAIL b2b cycle %0d {a,b,busy,done}: got %b want %b", i + 1, got_v, exp_v[i]);
      end
    end
    start = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || hit_cnt !== CNT_W'(1) || err !== 1'b0) begin
      errors++;
      $display("FAIL b2b end: busy=%b hit=%0d err=%b want 0 1 0", busy, hit_cnt, err);
    end
  endtask

  task automatic test_random();
    int n, g, len, pos;
    bit v;
    for (int it = 0; it < 8; it++) begin
      n   = $urandom_range(0, 6);
      g   = $urandom_range(0, 4);
      len = (n == 0) ? 1 : 3 * n + (n - 1) * g + 1;
      pos = ($urandom_range(0, 2) == 0) ? -1 : $urandom_range(1, len);
      v   = 1'($urandom_range(0, 1));
      do_run(n, g, pos, v, $sformatf("rand%0d_c%0d_g%0d_p%0d_v%0d", it, n, g, pos, v));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gap();
    test_zero();
    test_miss();
    test_after_err();
    test_gap_hit();
    test_idle_y();
    test_midrun_reset();
    test_back_to_back();
    test_max();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
